// File: rtl/bcd_wrap_counter.sv
// bcd_wrap_counter
//   N-digit packed-BCD up/down counter confined to [MIN_VAL, MAX_VAL].
//   Stepping past either end wraps to the other end, toggles the phase
//   flag and raises the combinational carry so chained stages (carry -> en)
//   roll over on the same clock edge.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high; forces RESET_VAL / RESET_PHASE
//   en         in   one step per cycle while high
//   down       in   step direction: 0 = up, 1 = down
//   load       in   synchronous load request (wins over en)
//   load_data  in   W-bit packed BCD value to load
//   count      out  registered packed BCD count
//   carry      out  combinational: the step taken this cycle wraps
//   phase      out  registered; toggles on every wrap
//   load_err   out  registered one-cycle pulse after a rejected load
module bcd_wrap_counter #(
  parameter int          DIGITS      = 2,
  parameter logic [15:0] MIN_VAL     = 16'h0001,
  parameter logic [15:0] MAX_VAL     = 16'h0012,
  parameter logic [15:0] RESET_VAL   = 16'h0012,
  parameter logic        RESET_PHASE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_data,
  output logic [4*DIGITS-1:0]   count,
  output logic                  carry,
  output logic                  phase,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] MINV = MIN_VAL[W-1:0];
  localparam logic [W-1:0] MAXV = MAX_VAL[W-1:0];
  localparam logic [W-1:0] RSTV = RESET_VAL[W-1:0];

  // True when every nibble is a legal decimal digit.
  function automatic logic digits_ok(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Digit-wise +1: a 9 becomes 0 and ripples into the next digit.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Digit-wise -1: a 0 becomes 9 and borrows from the next digit.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Elaboration-time parameter sanity.
  localparam logic PARAM_OK = (DIGITS >= 1) && (DIGITS <= 4) &&
                              digits_ok(MINV) && digits_ok(MAXV) && digits_ok(RSTV) &&
                              (MINV < MAXV) && (RSTV >= MINV) && (RSTV <= MAXV);
  generate
    if (!PARAM_OK) begin : g_bad_params
      $error("bcd_wrap_counter: illegal DIGITS/MIN_VAL/MAX_VAL/RESET_VAL combination");
    end
  endgenerate

  logic [W-1:0] r_count;
  logic         r_phase;
  logic         r_load_err;
  logic         w_at_end;
  logic         w_wrap;
  logic         w_load_ok;
  logic [W-1:0] w_step_val;

  // The end of the range the current direction runs into.
  assign w_at_end   = down ? (r_count == MINV) : (r_count == MAXV);
  assign w_wrap     = en & ~load & w_at_end;
  assign w_load_ok  = digits_ok(load_data) && (load_data >= MINV) && (load_data <= MAXV);
  assign w_step_val = w_at_end ? (down ? MAXV : MINV)
                               : (down ? bcd_dec(r_count) : bcd_inc(r_count));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count    <= RSTV;
      r_phase    <= RESET_PHASE;
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= 1'b0;
      if (load) begin
        if (w_load_ok) r_count    <= load_data;
        else           r_load_err <= 1'b1;
      end else if (en) begin
        r_count <= w_step_val;
        if (w_at_end) r_phase <= ~r_phase;
      end
    end
  end

  assign count    = r_count;
  assign carry    = w_wrap;
  assign phase    = r_phase;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_wrap_counter.sv
module tb_bcd_wrap_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, en, down, load, ch_load;
  logic [7:0] load_data, lo_data, hi_data;
  logic [7:0] c0, clo, chi;
  logic       k0, klo, khi, p0, plo, phi, e0, elo, ehi;

  int checks = 0;
  int errors = 0;

  // Default instance: 12 h style 01..12.
  bcd_wrap_counter u0 (
    .clk(clk), .reset(reset), .en(en), .down(down), .load(load),
    .load_data(load_data), .count(c0), .carry(k0), .phase(p0), .load_err(e0)
  );

  // Two 00..59 stages chained through carry.
  bcd_wrap_counter #(.DIGITS(2), .MIN_VAL(16'h0000), .MAX_VAL(16'h0059),
                     .RESET_VAL(16'h0000), .RESET_PHASE(1'b0)) u_lo (
    .clk(clk), .reset(reset), .en(en), .down(down), .load(ch_load),
    .load_data(lo_data), .count(clo), .carry(klo), .phase(plo), .load_err(elo)
  );

  bcd_wrap_counter #(.DIGITS(2), .MIN_VAL(16'h0000), .MAX_VAL(16'h0059),
                     .RESET_VAL(16'h0000), .RESET_PHASE(1'b0)) u_hi (
    .clk(clk), .reset(reset), .en(klo), .down(down), .load(ch_load),
    .load_data(hi_data), .count(chi), .carry(khi), .phase(phi), .load_err(ehi)
  );

  typedef struct {
    logic [7:0] c0;  logic p0;  logic e0;
    logic [7:0] lo;  logic plo; logic elo;
    logic [7:0] hi;  logic phi; logic ehi;
  } exp_t;

  exp_t q[$];
  exp_t mon_x;

  // Reference model state held as plain integers.
  int m0, mlo, mhi;
  bit mp0, mplo, mphi;

  function automatic int bcd2int(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic bit bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic [7:0] int2bcd(input int n);
    logic [3:0] t, o;
    t = 4'(n / 10);
    o = 4'(n % 10);
    return {t, o};
  endfunction

  // One cycle of a range counter in integer terms; wrap is the expected carry.
  task automatic mstep(inout int c, inout bit p, output bit err, output bit wrap,
                       input int lo, input int hi, input bit e, input bit d,
                       input bit ld, input logic [7:0] data);
    err  = 1'b0;
    wrap = 1'b0;
    if (ld) begin
      if (bcd_ok(data) && bcd2int(data) >= lo && bcd2int(data) <= hi) c = bcd2int(data);
      else err = 1'b1;
    end else if (e) begin
      if (!d) begin
        if (c == hi) begin c = lo; wrap = 1'b1; end
        else c = c + 1;
      end else begin
        if (c == lo) begin c = hi; wrap = 1'b1; end
        else c = c - 1;
      end
    end
    if (wrap) p = ~p;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one cycle of stimulus, check carries now, queue the post-edge state.
  task automatic step(input bit e, input bit d, input bit ld, input logic [7:0] data,
                      input bit cld, input logic [7:0] ldat, input logic [7:0] hdat);
    exp_t x;
    bit w0, wl, wh, er0, erl, erh;
    @(negedge clk);
    en = e; down = d; load = ld; load_data = data;
    ch_load = cld; lo_data = ldat; hi_data = hdat;
    mstep(m0,  mp0,  er0, w0, 1, 12, e,  d, ld,  data);
    mstep(mlo, mplo, erl, wl, 0, 59, e,  d, cld, ldat);
    mstep(mhi, mphi, erh, wh, 0, 59, wl, d, cld, hdat);
    #1;
    chk("carry0",   16'(k0),  16'(w0));
    chk("carry_lo", 16'(klo), 16'(wl));
    chk("carry_hi", 16'(khi), 16'(wh));
    x.c0 = int2bcd(m0);  x.p0 = mp0;   x.e0 = er0;
    x.lo = int2bcd(mlo); x.plo = mplo; x.elo = erl;
    x.hi = int2bcd(mhi); x.phi = mphi; x.ehi = erh;
    q.push_back(x);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
  endtask

  // Monitor: every registered update is compared against the queued model state.
  always @(posedge clk) begin
    #1;
    if (!reset && q.size() > 0) begin
      mon_x = q.pop_front();
      chk("count0",    16'(c0),  16'(mon_x.c0));
      chk("phase0",    16'(p0),  16'(mon_x.p0));
      chk("load_err0", 16'(e0),  16'(mon_x.e0));
      chk("count_lo",  16'(clo), 16'(mon_x.lo));
      chk("phase_lo",  16'(plo), 16'(mon_x.plo));
      chk("err_lo",    16'(elo), 16'(mon_x.elo));
      chk("count_hi",  16'(chi), 16'(mon_x.hi));
      chk("phase_hi",  16'(phi), 16'(mon_x.phi));
      chk("err_hi",    16'(ehi), 16'(mon_x.ehi));
    end
  end

  task automatic model_reset();
    m0 = 12; mp0 = 1'b0;
    mlo = 0; mplo = 1'b0;
    mhi = 0; mphi = 1'b0;
  endtask

  task automatic rand_steps(input int n);
    logic [7:0] d0, dl, dh;
    for (int i = 0; i < n; i++) begin
      d0 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : int2bcd($urandom_range(0, 13));
      dl = ($urandom_range(0, 3) == 0) ? 8'($urandom) : int2bcd($urandom_range(0, 59));
      dh = ($urandom_range(0, 3) == 0) ? 8'($urandom) : int2bcd($urandom_range(0, 59));
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 5) == 0), d0,
           1'($urandom_range(0, 7) == 0), dl, dh);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; down = 1'b0; load = 1'b0; ch_load = 1'b0;
    load_data = 8'h00; lo_data = 8'h00; hi_data = 8'h00;
    model_reset();
    #2;
    chk("reset_count0", 16'(c0), 16'h0012);
    chk("reset_phase0", 16'(p0), 16'h0000);
    chk("reset_err0",   16'(e0), 16'h0000);
    chk("reset_count_lo", 16'(clo), 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // Hold idle, then wrap up from the top and ripple 09 -> 10.
    repeat (5) idle();
    repeat (10) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);

    // Down wrap from MIN and a digit borrow.
    step(1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);

    // Valid and rejected loads, then load together with en.
    step(1'b0, 1'b0, 1'b1, 8'h07, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h13, 1'b0, 8'h00, 8'h00);
    idle();
    step(1'b0, 1'b0, 1'b1, 8'h1A, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b0, 1'b1, 8'h05, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);

    // Chain 59:59 -> 00:00 on one edge, then back down to 59:59.
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h59, 8'h59);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h6A, 1'b1, 8'h60, 8'h5B);

    rand_steps(300);

    // Asynchronous reset between edges with en=1 at count 05, after a wrap.
    step(1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h33, 8'h21);
    step(1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 8'h00, 8'h00);
    @(posedge clk);
    @(negedge clk);
    en = 1'b1; down = 1'b0; load = 1'b0; ch_load = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_count0",   16'(c0),  16'h0012);
    chk("async_phase0",   16'(p0),  16'h0000);
    chk("async_count_lo", 16'(clo), 16'h0000);
    chk("async_count_hi", 16'(chi), 16'h0000);
    @(posedge clk);
    #2;
    chk("held_count0", 16'(c0), 16'h0012);
    chk("held_err0",   16'(e0), 16'h0000);
    @(negedge clk);
    reset = 1'b0; en = 1'b0;
    model_reset();

    rand_steps(200);

    @(posedge clk);
    #3;
    chk("queue_drained", 16'(q.size()), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_wrap_counter.md
# bcd_wrap_counter

Parametrised N-digit BCD up/down counter with a programmable range [MIN_VAL, MAX_VAL], a synchronous checked load, a combinational wrap-carry for chaining, and a wrap-parity phase flag.
It is the generalised successor to the fixed-range clock registers.
One instance covers seconds (00–59), minutes (00–59), 12 h hours (01–12 with AM/PM phase), 24 h hours (00–23) or day-of-month style ranges.
Stages chain by feeding `carry` into the next stage's `en`.

## Interface
Parameters:
- DIGITS, 2, number of BCD digits (1..4); counter width W = 4*DIGITS
- MIN_VAL, 16'h0001, lowest count, packed BCD (only low W bits used)
- MAX_VAL, 16'h0012, highest count, packed BCD; must satisfy MIN_VAL < MAX_VAL with all digits 0–9
- RESET_VAL, 16'h0012, count after reset, packed BCD within range
- RESET_PHASE, 1'b0, phase after reset

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- en  in  1  step strobe, one step per cycle asserted
- down  in  1  direction when en: 0 = increment, 1 = decrement
- load  in  1  synchronous load request
- load_data  in  W  packed BCD value to load
- count  out  W  current count, packed BCD, registered
- carry  out  1  combinational: this step wraps
- phase  out  1  registered; toggles on every wrap (AM/PM for 12 h use)
- load_err  out  1  registered one-cycle pulse: rejected load

## Operation
- Reset (asserted at any time, including mid-step or mid-load):
  - count = RESET_VAL[W-1:0], phase = RESET_PHASE, load_err = 0, immediately and held while reset is high.
  - First update happens on the first clk edge after reset is released.
- Priority per cycle: load > en > hold.
- Load:
  - Valid when every digit of load_data is ≤ 9 and MIN_VAL ≤ load_data ≤ MAX_VAL (unsigned compare; correct for valid BCD).
  - Valid load: count = load_data; phase unchanged; load_err = 0.
  - Invalid load: count and phase unchanged; load_err = 1 for one cycle.
  - en is ignored in any cycle with load = 1, valid or not.
- Increment (en=1, down=0, load=0):
  - count == MAX_VAL: count = MIN_VAL, phase toggles.
  - Otherwise BCD +1: digit 9 → 0 with ripple into the next digit; other digits +1.
- Decrement (en=1, down=1, load=0):
  - count == MIN_VAL: count = MAX_VAL, phase toggles.
  - Otherwise BCD −1: digit 0 → 9 with borrow into the next digit.
- carry = en & ~load & (down ? count==MIN_VAL : count==MAX_VAL). This is the same condition that toggles phase.
- Counts are never outside [MIN_VAL, MAX_VAL]; no binary intermediate values are used (digit-wise BCD arithmetic only).
- Parameter checks: elaboration fails (generate-time error) if MIN_VAL ≥ MAX_VAL, if any digit > 9, or if RESET_VAL is out of range.

## Timing
- count, phase and load_err update on the clk rising edge following the request: latency 1.
- load_err is high for exactly the cycle after a rejected load; it is 0 in every other cycle.
- carry is combinational from count, en, down and load in the same cycle. Chained stages see it before the shared edge, so the whole chain rolls on one edge (e.g. 59:59 → 00:00 in one cycle).
- en held high steps every cycle; no minimum spacing between requests.
- Changing down between cycles takes effect on the next step; there is no hysteresis.

## Test plan
- Defaults, reset: count=0x12, phase=0, load_err=0. Release reset, hold all inputs 0 for 5 cycles: count stays 0x12.
- Defaults, single up step from 0x12: carry=1 during the step cycle; next cycle count=0x01, phase=1. Then 9 more up steps: 0x09 → 0x10 digit ripple, count=0x10, carry=0 throughout.
- Defaults, load 0x01 then one down step: carry=1; next cycle count=0x12 and phase toggled. A down step from 0x10 gives 0x09.
- Defaults, loads: 0x07 → count=0x07, load_err=0. 0x13 → count unchanged, load_err=1 for one cycle. 0x1A → rejected. 0x00 → rejected (below MIN). load=1 with en=1 → load applied, carry=0.
- DIGITS=2, MIN_VAL=0x00, MAX_VAL=0x59: two instances chained (carry→en), both at 0x59 with en=1. After one edge both are 0x00 and both phases toggled. A down step from 0x00 gives 0x59.
- Assert reset asynchronously mid-sequence (between edges, with en=1 at count=0x05): count returns to RESET_VAL and phase to RESET_PHASE before the next edge. No step occurs while reset is held.
